// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA raster timing generator:
//   - default 640x480 timing constants and output widths
//   - derived line/frame total helper
//   - FSM state encoding (IDLE = 0, RUN = 1, STOPPING = 2)
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int COORD_W = 12;   // width of coordinates and raster counters
   localparam int FCNT_W  = 16;   // width of the completed-frame counter

   // Default 640x480 @ 60 Hz timing
   localparam int DEF_H_ACT  = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_V_ACT  = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } vga_state_e;

   // Total clocks per line (or lines per frame) from its four segments
   function automatic int timing_total(input int act, input int fp,
                                       input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int h_total(input int act, input int fp,
                                  input int sync, input int bp);
      return timing_total(act, fp, sync, bp);
   endfunction

   function automatic int v_total(input int act, input int fp,
                                  input int sync, input int bp);
      return timing_total(act, fp, sync, bp);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle between the timing generator and the pixel pipeline.
//   iRun        : run request (consumer/harness -> generator)
//   oVGA_X/Y    : active-area coordinates
//   oActive     : coordinates valid
//   oEnd_Frame  : vertical blanking indication
//   oH_SYNC/oV_SYNC/oBLANK_n : delayed sync/blank towards the DAC
//   oFrame_cnt  : completed-frame counter
// master = generator side, slave = consumer side.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic               iRun;
   logic [COORD_W-1:0] oVGA_X;
   logic [COORD_W-1:0] oVGA_Y;
   logic               oActive;
   logic               oEnd_Frame;
   logic               oH_SYNC;
   logic               oV_SYNC;
   logic               oBLANK_n;
   logic [FCNT_W-1:0]  oFrame_cnt;

   modport master (
      input  iRun,
      output oVGA_X, oVGA_Y, oActive, oEnd_Frame,
             oH_SYNC, oV_SYNC, oBLANK_n, oFrame_cnt
   );

   modport slave (
      output iRun,
      input  oVGA_X, oVGA_Y, oActive, oEnd_Frame,
             oH_SYNC, oV_SYNC, oBLANK_n, oFrame_cnt
   );
endinterface

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// DEPTH-deep, W-bit shift register with a reset-value input. DEPTH = 0 is a
// plain wire.
//   clk_i     : clock
//   rst_n_i   : asynchronous active-low reset
//   rst_val_i : value loaded into every stage on reset
//   d_i       : data in
//   q_o       : data out, DEPTH cycles later
// -----------------------------------------------------------------------------
module vga_delay_line #(
   parameter int DEPTH = 1,
   parameter int W     = 3
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [W-1:0] rst_val_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign q_o = d_i;
      end else begin : g_shift
         logic [W-1:0] stage_q [DEPTH];

         // Shift chain; reset fills every stage with the deasserted pattern
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage_q[i] <= rst_val_i;
               end
            end else begin
               stage_q[0] <= d_i;
               for (int i = 1; i < DEPTH; i++) begin
                  stage_q[i] <= stage_q[i-1];
               end
            end
         end

         assign q_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator: horizontal/vertical counters, run/stop FSM that
// only stops on a frame boundary, registered coordinates and a delayed
// sync/blank path aligned with the consumer's registered colour outputs.
//   iVGA_CLK : pixel clock
//   iRST_n   : asynchronous active-low reset
//   vga      : vga_timing_gen_if.master (iRun in, timing outputs out)
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACT    = DEF_H_ACT,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACT    = DEF_V_ACT,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int SYNC_POL = 0,
   parameter int PIPE_DLY = 1
) (
   input  logic             iVGA_CLK,
   input  logic             iRST_n,
   vga_timing_gen_if.master vga
);

   localparam int H_TOT = h_total(H_ACT, H_FP, H_SYNC, H_BP);
   localparam int V_TOT = v_total(V_ACT, V_FP, V_SYNC, V_BP);

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
   localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACT);
   localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACT);
   localparam logic [COORD_W-1:0] H_SS     = COORD_W'(H_ACT + H_FP);
   localparam logic [COORD_W-1:0] H_SE     = COORD_W'(H_ACT + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] V_SS     = COORD_W'(V_ACT + V_FP);
   localparam logic [COORD_W-1:0] V_SE     = COORD_W'(V_ACT + V_FP + V_SYNC);
   localparam logic               SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
   localparam logic               SYNC_OFF = ~SYNC_ON;
   // {hs, vs, blank_n} when nothing is being displayed
   localparam logic [2:0]         SYNC_RST = {SYNC_OFF, SYNC_OFF, 1'b0};

   vga_state_e         state_q, state_d;
   logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
   logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic               active_q, active_d;
   logic               eof_q, eof_d;
   logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [2:0]         sync_q, sync_d;
   logic [2:0]         dly_s;

   logic running_s, h_last_s, v_last_s, frame_wrap_s;
   logic active_s, hs_on_s, vs_on_s;

   assign running_s    = (state_q != ST_IDLE);
   assign h_last_s     = (h_cnt_q == H_LAST);
   assign v_last_s     = (v_cnt_q == V_LAST);
   // Last clock of a frame while counting; the only point where stopping is allowed
   assign frame_wrap_s = running_s && h_last_s && v_last_s;

   assign active_s = running_s && (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
   assign hs_on_s  = running_s && (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
   assign vs_on_s  = running_s && (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);

   // Run/stop FSM next state; iRun returning during STOPPING wins over the wrap
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (vga.iRun) state_d = ST_RUN;
            else          state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (!vga.iRun) state_d = ST_STOPPING;
            else           state_d = ST_RUN;
         end
         ST_STOPPING: begin
            if (vga.iRun)         state_d = ST_RUN;
            else if (frame_wrap_s) state_d = ST_IDLE;
            else                  state_d = ST_STOPPING;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Raster counters: held at 0 in IDLE, so RUN always starts at h=0, v=0
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (!running_s) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (h_last_s) begin
         h_cnt_d = '0;
         if (v_last_s) v_cnt_d = '0;
         else          v_cnt_d = v_cnt_q + COORD_W'(1);
      end else begin
         h_cnt_d = h_cnt_q + COORD_W'(1);
      end
   end

   // Next values of the output registers derived from the current counter state
   always_comb begin
      x_d         = active_s ? h_cnt_q : '0;
      y_d         = (running_s && (v_cnt_q < V_ACT_C)) ? v_cnt_q : '0;
      active_d    = active_s;
      eof_d       = running_s && (v_cnt_q >= V_ACT_C);
      sync_d      = {hs_on_s ? SYNC_ON : SYNC_OFF, vs_on_s ? SYNC_ON : SYNC_OFF, active_s};
      if (frame_wrap_s) frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      else              frame_cnt_d = frame_cnt_q;
   end

   // State, counters and first output stage
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q     <= ST_IDLE;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         x_q         <= '0;
         y_q         <= '0;
         active_q    <= 1'b0;
         eof_q       <= 1'b0;
         frame_cnt_q <= '0;
         sync_q      <= SYNC_RST;
      end else begin
         state_q     <= state_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         active_q    <= active_d;
         eof_q       <= eof_d;
         frame_cnt_q <= frame_cnt_d;
         sync_q      <= sync_d;
      end
   end

   // Sync/blank get PIPE_DLY extra cycles to line up with the colour registers
   vga_delay_line #(
      .DEPTH (PIPE_DLY),
      .W     (3)
   ) u_dly (
      .clk_i     (iVGA_CLK),
      .rst_n_i   (iRST_n),
      .rst_val_i (SYNC_RST),
      .d_i       (sync_q),
      .q_o       (dly_s)
   );

   assign vga.oVGA_X     = x_q;
   assign vga.oVGA_Y     = y_q;
   assign vga.oActive    = active_q;
   assign vga.oEnd_Frame = eof_q;
   assign vga.oFrame_cnt = frame_cnt_q;
   assign vga.oH_SYNC    = dly_s[2];
   assign vga.oV_SYNC    = dly_s[1];
   assign vga.oBLANK_n   = dly_s[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Bench for vga_timing_gen using a small 15x8 raster. A behavioural model
// pushes the expected outputs for each clock into scoreboard queues; they are
// popped and compared once the DUT has registered (and delayed) them.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   localparam int H_ACT = 8, H_FP = 2, H_SYNC = 3, H_BP = 2, H_TOT = 15;
   localparam int V_ACT = 4, V_FP = 1, V_SYNC = 2, V_BP = 1, V_TOT = 8;
   localparam int PIPE_DLY = 1;
   localparam int SYNC_POL = 0;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic        act;
      logic        eof;
      logic [15:0] fcnt;
   } coord_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   vga_timing_gen_if vif ();

   vga_timing_gen #(
      .H_ACT (H_ACT), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACT (V_ACT), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .SYNC_POL (SYNC_POL), .PIPE_DLY (PIPE_DLY)
   ) u_dut (
      .iVGA_CLK (clk),
      .iRST_n   (rst_n),
      .vga      (vif)
   );

   // Pixel clock
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: 0 idle, 1 run, 2 stopping
   int          m_state;
   int          m_h;
   int          m_v;
   logic [15:0] m_fcnt;

   coord_t      coord_q [$];
   logic [2:0]  sync_q  [$];

   int st_active, st_hs, st_vs, st_eof, st_x1y1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_h     = 0;
      m_v     = 0;
      m_fcnt  = 16'h0000;
      coord_q.delete();
      sync_q.delete();
      // delay line comes out of reset holding deasserted values
      for (int i = 0; i < PIPE_DLY; i++) sync_q.push_back(3'b110);
   endtask

   task automatic clear_stats();
      st_active = 0; st_hs = 0; st_vs = 0; st_eof = 0; st_x1y1 = 0;
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_x"},     32'(vif.oVGA_X),     32'd0);
      check_eq({tag, "_y"},     32'(vif.oVGA_Y),     32'd0);
      check_eq({tag, "_act"},   32'(vif.oActive),    32'd0);
      check_eq({tag, "_eof"},   32'(vif.oEnd_Frame), 32'd0);
      check_eq({tag, "_hs"},    32'(vif.oH_SYNC),    32'd1);
      check_eq({tag, "_vs"},    32'(vif.oV_SYNC),    32'd1);
      check_eq({tag, "_blank"}, 32'(vif.oBLANK_n),   32'd0);
      check_eq({tag, "_fcnt"},  32'(vif.oFrame_cnt), 32'd0);
   endtask

   // One clock: push expectation, advance model, clock the DUT, compare
   task automatic tick();
      coord_t     ec, got;
      logic [2:0] es, gs;
      logic       run_m, act, hs, vs, wrap;
      run_m = (m_state != 0);
      act   = run_m && (m_h < H_ACT) && (m_v < V_ACT);
      hs    = run_m && (m_h >= H_ACT + H_FP) && (m_h < H_ACT + H_FP + H_SYNC);
      vs    = run_m && (m_v >= V_ACT + V_FP) && (m_v < V_ACT + V_FP + V_SYNC);
      wrap  = run_m && (m_h == H_TOT - 1) && (m_v == V_TOT - 1);
      ec.x    = act ? 12'(m_h) : 12'd0;
      ec.y    = (run_m && (m_v < V_ACT)) ? 12'(m_v) : 12'd0;
      ec.act  = act;
      ec.eof  = run_m && (m_v >= V_ACT);
      ec.fcnt = wrap ? m_fcnt + 16'd1 : m_fcnt;
      es      = {~hs, ~vs, act};
      coord_q.push_back(ec);
      sync_q.push_back(es);

      case (m_state)
         0:       if (vif.iRun) m_state = 1;
         1:       if (!vif.iRun) m_state = 2;
         2:       if (vif.iRun) m_state = 1; else if (wrap) m_state = 0;
         default: m_state = 0;
      endcase
      if (!run_m) begin
         m_h = 0;
         m_v = 0;
      end else if (m_h == H_TOT - 1) begin
         m_h = 0;
         m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
      end else begin
         m_h++;
      end
      m_fcnt = ec.fcnt;

      @(posedge clk);
      #1;
      got = coord_q.pop_front();
      gs  = sync_q.pop_front();
      check_eq("x",     32'(vif.oVGA_X),     32'(got.x));
      check_eq("y",     32'(vif.oVGA_Y),     32'(got.y));
      check_eq("act",   32'(vif.oActive),    32'(got.act));
      check_eq("eof",   32'(vif.oEnd_Frame), 32'(got.eof));
      check_eq("fcnt",  32'(vif.oFrame_cnt), 32'(got.fcnt));
      check_eq("hs",    32'(vif.oH_SYNC),    32'(gs[2]));
      check_eq("vs",    32'(vif.oV_SYNC),    32'(gs[1]));
      check_eq("blank", 32'(vif.oBLANK_n),   32'(gs[0]));

      if (vif.oActive)     st_active++;
      if (!vif.oH_SYNC)    st_hs++;
      if (!vif.oV_SYNC)    st_vs++;
      if (vif.oEnd_Frame)  st_eof++;
      if (vif.oActive && vif.oVGA_X == 12'd1 && vif.oVGA_Y == 12'd1) st_x1y1++;
   endtask

   // Run until the model has reached IDLE, bounded
   task automatic run_to_idle(input string tag);
      int n;
      n = 0;
      while (m_state != 0 && n < 300) begin
         tick();
         n++;
      end
      check_eq({tag, "_idle_reached"}, 32'(m_state == 0), 32'd1);
   endtask

   initial begin
      int first_act, first_hs, n;

      vif.iRun = 1'b0;
      rst_n    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      check_reset("por");
      rst_n = 1'b1;

      // 1: idle with iRun low
      repeat (50) tick();
      check_reset("idle50");

      // 2/3: two full frames
      vif.iRun  = 1'b1;
      clear_stats();
      first_act = -1;
      first_hs  = -1;
      for (int i = 0; i < 241; i++) begin
         tick();
         if (first_act < 0 && vif.oActive) first_act = i;
         if (first_hs < 0 && !vif.oH_SYNC) first_hs = i;
      end
      check_eq("hs_offset",   32'(first_hs - first_act), 32'd11);
      check_eq("active_cnt",  32'(st_active), 32'd64);
      check_eq("hs_low_cnt",  32'(st_hs),     32'd48);
      check_eq("vs_low_cnt",  32'(st_vs),     32'd60);
      check_eq("eof_cnt",     32'(st_eof),    32'd120);
      check_eq("x1y1_cnt",    32'(st_x1y1),   32'd2);
      check_eq("fcnt_2",      32'(vif.oFrame_cnt), 32'd2);

      // 4: drop iRun mid-frame, re-raise before wrap, then stop for real
      clear_stats();
      n = 0;
      while (!(m_v == 2 && m_h == 0) && n < 200) begin tick(); n++; end
      check_eq("reach_f3_line2", 32'(m_v == 2), 32'd1);
      vif.iRun = 1'b0;
      n = 0;
      while (m_v != 5 && n < 200) begin tick(); n++; end
      check_eq("reach_f3_line5", 32'(m_v == 5), 32'd1);
      vif.iRun = 1'b1;
      n = 0;
      while (!(m_v == 2 && m_h == 0) && n < 200) begin tick(); n++; end
      check_eq("reach_f4_line2", 32'(m_v == 2), 32'd1);
      vif.iRun = 1'b0;
      run_to_idle("stop");
      repeat (3) tick();
      check_eq("stop_active_cnt", 32'(st_active), 32'd64);
      check_eq("stop_fcnt",       32'(vif.oFrame_cnt), 32'd4);
      check_eq("stop_act_low",    32'(vif.oActive), 32'd0);

      // 5: asynchronous reset mid-line at X=5
      vif.iRun = 1'b1;
      n = 0;
      while (!(vif.oActive && vif.oVGA_X == 12'd5) && n < 60) begin tick(); n++; end
      check_eq("reach_x5", 32'(vif.oVGA_X), 32'd5);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset("async");
      model_reset();
      #2;
      rst_n = 1'b1;
      repeat (2) tick();
      check_eq("restart_x",   32'(vif.oVGA_X),  32'd0);
      check_eq("restart_y",   32'(vif.oVGA_Y),  32'd0);
      check_eq("restart_act", 32'(vif.oActive), 32'd1);

      // 6: frame counter wrap from 0xFFFF
      vif.iRun = 1'b0;
      run_to_idle("pre_wrap");
      tick();
      force u_dut.frame_cnt_q = 16'hFFFF;
      #1;
      release u_dut.frame_cnt_q;
      m_fcnt = 16'hFFFF;
      check_eq("fcnt_preload", 32'(vif.oFrame_cnt), 32'h0000FFFF);
      vif.iRun = 1'b1;
      tick();
      vif.iRun = 1'b0;
      run_to_idle("wrap");
      tick();
      check_eq("fcnt_wrap", 32'(vif.oFrame_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time limit
   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
